fsm_par_join: RTL and testbench
===============================

FSM_PAR_JOIN -- requirements
Module: fsm_par_join

Interface
REQ-001 Parameter N, default 3, number of parallel child groups (legal range 1..8).
REQ-002 Parameter CW, default 16, width of the RUN-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low (asserted when 0).
REQ-005 valid  input  1  go request from the parent controller.
REQ-006 ready  output  1  done pulse to the parent controller.
REQ-007 valid_child  output  N  per-child go; bit i drives child group i.
REQ-008 ready_child  input  N  per-child done; bit i comes from child group i.
REQ-009 cycles  output  CW  number of cycles spent in RUN during the last or current activation.

Function
REQ-010 The block SHALL implement three states: IDLE=2'd0, RUN=2'd1, DONE=2'd2; the encoding 2'd3 SHALL go to IDLE on the next edge.
REQ-011 IDLE: if valid==1, the block SHALL go to RUN, clear done_mask (N bits) and clear cycles; otherwise it SHALL stay in IDLE.
REQ-012 RUN: valid_child[i] SHALL equal ~done_mask[i] combinationally; all outputs SHALL be 0 in IDLE and DONE except as stated.
REQ-013 RUN: done_mask[i] SHALL be set on any edge where valid_child[i]==1 and ready_child[i]==1; valid_child[i] SHALL be 0 from the next cycle on.
REQ-014 RUN: when (done_mask | (ready_child & valid_child)) is all ones, the block SHALL go to DONE on that edge.
REQ-015 ready_child[i] SHALL be ignored while valid_child[i]==0, including in IDLE and DONE.
REQ-016 Children SHALL complete in any order, including all children in the same cycle.
REQ-017 DONE: ready SHALL be 1 for exactly one cycle; the block SHALL then go to IDLE unconditionally.
REQ-018 Minimum latency: valid sampled at edge t, RUN during cycle t+1, all ready_child high in that cycle, and ready high during cycle t+2.
REQ-019 valid deasserted during RUN SHALL NOT abort the activation; valid held high through DONE SHALL start a new activation only after IDLE is reached.
REQ-020 cycles SHALL increment by 1 on every edge spent in RUN, saturate at 2^CW-1 without wrapping, and hold its value in DONE and IDLE until the next IDLE->RUN transition.
REQ-021 For N=1, the block SHALL behave as a single enable wrapper with identical timing.

Reset
REQ-022 While reset==0, the block SHALL asynchronously force state=IDLE, done_mask=0, cycles=0, ready=0 and valid_child=0.
REQ-023 Reset asserted mid-RUN SHALL abandon the activation with no ready pulse; after release the block SHALL wait in IDLE for a new valid.
REQ-024 The first valid SHALL be sampled on the first rising edge after reset deasserts.

Structure
REQ-025 The state enum type, STATE_W=2 and the state encodings SHALL reside in the shared package fsm_pkg, for reuse by the seq and enable controllers.
REQ-026 The block SHALL be a single module with one sequential process and one combinational next-state/output process, and no sub-module.

Verification
REQ-027 N=3: valid pulse at cycle 0, all ready_child=3'b111 in cycle 1 -> ready=1 in cycle 2 only, cycles=1, valid_child=3'b111 in cycle 1 only.
REQ-028 N=3: children complete at RUN cycles 2, 5 and 3 (bits 0, 1, 2) -> valid_child goes 111, 110, 010, then 000 in DONE, ready one cycle after the bit-1 completion, cycles=5.
REQ-029 ready_child=3'b111 held constantly while IDLE, then valid -> no early completion, no ready before RUN, ready two cycles after valid.
REQ-030 reset driven low in RUN cycle 3 -> valid_child=0 and cycles=0 immediately with no clock edge; no ready pulse; a later valid completes normally.
REQ-031 CW=4: one child held not-ready for 20 RUN cycles -> cycles saturates at 15, ready still pulses once; valid held high throughout -> a second activation starts after one IDLE cycle.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared FSM definitions for the seq, enable and parallel-join controllers.
// Contents:
//   STATE_W - width of the controller state register
//   state_t - controller states IDLE / RUN / DONE (encoding 2'd3 is unused)
package fsm_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsm_par_join.sv
// Parallel fork/join controller. A parent go (valid) starts N child groups
// together; the block waits until every child has reported done, then gives
// the parent a one-cycle done pulse (ready). It also counts the cycles spent
// waiting in RUN.
// Ports:
//   clk         - clock, rising edge active
//   reset       - asynchronous reset, active low
//   valid       - go request from the parent controller
//   ready       - one-cycle done pulse to the parent controller
//   valid_child - per-child go, bit i drives child group i (N bits)
//   ready_child - per-child done, bit i from child group i (N bits)
//   cycles      - RUN cycles of the last or current activation, saturating (CW bits)
module fsm_par_join #(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  output logic          ready,
  output logic [N-1:0]  valid_child,
  input  logic [N-1:0]  ready_child,
  output logic [CW-1:0] cycles
);

  import fsm_pkg::*;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] done_mask;
  logic [N-1:0] handshake;

  // A child's done only counts while its go is asserted, so ready_child is
  // ignored in IDLE/DONE and for children that have already finished.
  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    valid_child = '0;
    handshake   = '0;
    case (state)
      IDLE: begin
        if (valid) state_nxt = RUN;
      end
      RUN: begin
        valid_child = ~done_mask;
        handshake   = ready_child & valid_child;
        if (&(done_mask | handshake)) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done_mask <= '0;
      cycles    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (valid) begin
            done_mask <= '0;
            cycles    <= '0;
          end
        end
        RUN: begin
          done_mask <= done_mask | handshake;
          if (cycles != '1) cycles <= cycles + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_par_join.sv
module tb_fsm_par_join;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [2:0]  valid_child;
  logic [2:0]  ready_child;
  logic [15:0] cycles;

  logic        s_reset;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_valid_child;
  logic [2:0]  s_ready_child;
  logic [3:0]  s_cycles;

  int checks = 0;
  int errors = 0;

  // expected 'cycles' value at each ready pulse, per DUT
  int exp_q[$];
  int s_exp_q[$];

  fsm_par_join #(.N(3), .CW(16)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready),
    .valid_child(valid_child), .ready_child(ready_child), .cycles(cycles)
  );

  fsm_par_join #(.N(3), .CW(4)) u_sat (
    .clk(clk), .reset(s_reset), .valid(s_valid), .ready(s_ready),
    .valid_child(s_valid_child), .ready_child(s_ready_child), .cycles(s_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every ready pulse must match a pending expectation
  always @(negedge clk) begin
    #2;
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) chk("ready_unexpected", 32'd1, 32'd0);
      else chk("cycles_at_ready", 32'(cycles), 32'(exp_q.pop_front()));
    end
    if (s_ready === 1'b1) begin
      if (s_exp_q.size() == 0) chk("s_ready_unexpected", 32'd1, 32'd0);
      else chk("s_cycles_at_ready", 32'(s_cycles), 32'(s_exp_q.pop_front()));
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic obs(input string tag, input logic [2:0] vc, input logic rd);
    #1;
    chk({tag, "_vc"}, 32'(valid_child), 32'(vc));
    chk({tag, "_rdy"}, 32'(ready), 32'(rd));
  endtask

  task automatic s_obs(input string tag, input logic [2:0] vc, input logic rd, input int cyc);
    #1;
    chk({tag, "_vc"}, 32'(s_valid_child), 32'(vc));
    chk({tag, "_rdy"}, 32'(s_ready), 32'(rd));
    chk({tag, "_cyc"}, 32'(s_cycles), 32'(cyc));
  endtask

  logic [2:0] b_rc [1:5];
  logic [2:0] b_vc [1:5];

  initial begin
    reset = 1'b0; valid = 1'b0; ready_child = '0;
    s_reset = 1'b0; s_valid = 1'b0; s_ready_child = '0;
    b_rc[1] = 3'b000; b_rc[2] = 3'b001; b_rc[3] = 3'b100; b_rc[4] = 3'b000; b_rc[5] = 3'b010;
    b_vc[1] = 3'b111; b_vc[2] = 3'b111; b_vc[3] = 3'b110; b_vc[4] = 3'b010; b_vc[5] = 3'b010;

    // reset state
    nxt(); nxt();
    obs("reset", 3'b000, 1'b0);
    chk("reset_cycles", 32'(cycles), 32'd0);

    // minimum latency; valid on the first edge after reset release
    nxt(); reset = 1'b1; s_reset = 1'b1; valid = 1'b1; exp_q.push_back(1);
    obs("a_idle", 3'b000, 1'b0);
    nxt(); valid = 1'b0; ready_child = 3'b111;
    obs("a_run", 3'b111, 1'b0);
    nxt(); ready_child = 3'b000;
    obs("a_done", 3'b000, 1'b1);
    nxt();
    obs("a_idle2", 3'b000, 1'b0);
    chk("a_hold_cycles", 32'(cycles), 32'd1);

    // out-of-order completion at RUN cycles 2, 5, 3
    nxt(); valid = 1'b1; exp_q.push_back(5);
    obs("b_idle", 3'b000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      nxt(); valid = 1'b0; ready_child = b_rc[k];
      obs($sformatf("b_run%0d", k), b_vc[k], 1'b0);
      chk($sformatf("b_run%0d_cyc", k), 32'(cycles), 32'(k - 1));
    end
    nxt(); ready_child = 3'b000;
    obs("b_done", 3'b000, 1'b1);
    chk("b_cycles", 32'(cycles), 32'd5);

    // ready_child held high through IDLE must not complete anything early
    nxt(); ready_child = 3'b111;
    obs("c_idle0", 3'b000, 1'b0);
    nxt(); obs("c_idle1", 3'b000, 1'b0);
    nxt(); obs("c_idle2", 3'b000, 1'b0);
    nxt(); valid = 1'b1; exp_q.push_back(1);
    obs("c_valid", 3'b000, 1'b0);
    nxt(); valid = 1'b0;
    obs("c_run", 3'b111, 1'b0);
    nxt(); ready_child = 3'b000;
    obs("c_done", 3'b000, 1'b1);

    // reset during RUN cycle 3 abandons the activation
    nxt(); valid = 1'b1;
    obs("d_idle", 3'b000, 1'b0);
    nxt(); valid = 1'b0; ready_child = 3'b001;
    obs("d_run1", 3'b111, 1'b0);
    nxt(); ready_child = 3'b000;
    obs("d_run2", 3'b110, 1'b0);
    nxt();
    obs("d_run3", 3'b110, 1'b0);
    chk("d_run3_cyc", 32'(cycles), 32'd2);
    #2 reset = 1'b0;
    obs("d_async", 3'b000, 1'b0);
    chk("d_async_cyc", 32'(cycles), 32'd0);
    nxt(); reset = 1'b1;
    obs("d_rel", 3'b000, 1'b0);
    nxt(); obs("d_wait", 3'b000, 1'b0);
    nxt(); valid = 1'b1; exp_q.push_back(2);
    nxt(); valid = 1'b0; ready_child = 3'b011;
    obs("d2_run1", 3'b111, 1'b0);
    nxt(); ready_child = 3'b100;
    obs("d2_run2", 3'b100, 1'b0);
    nxt(); ready_child = 3'b000;
    obs("d2_done", 3'b000, 1'b1);

    // CW=4 saturation, valid held high across two activations
    nxt(); s_valid = 1'b1; s_exp_q.push_back(15);
    s_obs("e_idle", 3'b000, 1'b0, 0);
    for (int k = 1; k <= 21; k++) begin
      nxt();
      s_ready_child = (k == 1) ? 3'b101 : ((k == 21) ? 3'b010 : 3'b000);
      s_obs($sformatf("e_run%0d", k), (k == 1) ? 3'b111 : 3'b010, 1'b0, (k - 1 > 15) ? 15 : k - 1);
    end
    nxt(); s_ready_child = 3'b000;
    s_obs("e_done", 3'b000, 1'b1, 15);
    nxt(); s_exp_q.push_back(1);
    s_obs("e_idle2", 3'b000, 1'b0, 15);
    nxt(); s_ready_child = 3'b111;
    s_obs("e2_run", 3'b111, 1'b0, 0);
    nxt(); s_ready_child = 3'b000; s_valid = 1'b0;
    s_obs("e2_done", 3'b000, 1'b1, 1);
    nxt();
    s_obs("e2_idle", 3'b000, 1'b0, 1);
    nxt();
    s_obs("e2_idle2", 3'b000, 1'b0, 1);

    nxt(); #3;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("s_sb_empty", 32'(s_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
